// File: rtl/lfsr_modulator_if.sv
// Signal bundle between the slow-to-fast synchronizer/DDS side and the modulation stage.
// The master drives data, samples and the mode request. The slave returns the modulated output and status.
interface lfsr_modulator_if #(
   parameter int SAMPLE_W = 12,
   parameter int CNT_W    = 16
);
   logic                       data_bit;
   logic                       sample_en;
   logic signed [SAMPLE_W-1:0] sin_in;
   logic signed [SAMPLE_W-1:0] fsk_in;
   logic [1:0]                 mode_req;
   logic signed [SAMPLE_W-1:0] mod_out;
   logic                       mod_valid;
   logic [1:0]                 cur_mode;
   logic                       bit_edge;
   logic [CNT_W-1:0]           symbol_count;

   modport master (
      output data_bit, sample_en, sin_in, fsk_in, mode_req,
      input  mod_out, mod_valid, cur_mode, bit_edge, symbol_count
   );

   modport slave (
      input  data_bit, sample_en, sin_in, fsk_in, mode_req,
      output mod_out, mod_valid, cur_mode, bit_edge, symbol_count
   );
endinterface

// File: rtl/lfsr_modulator.sv
// Fast-domain ASK/FSK/BPSK/carrier modulator driven by the synchronized LFSR bit.
// A new mode is applied only when the data bit changes, so each symbol keeps a single mode from start to end.
module lfsr_modulator #(
   parameter int SAMPLE_W = 12,
   parameter int CNT_W    = 16
) (
   input logic             fast_clk,
   input logic             rst_n,
   lfsr_modulator_if.slave bus
);
   typedef enum logic [0:0] {
      WAIT_EDGE = 1'b0,
      RUN       = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0]           CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]           CNT_MAX  = {CNT_W{1'b1}};
   localparam logic signed [SAMPLE_W-1:0] SAMP_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic signed [SAMPLE_W-1:0] SAMP_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SAMPLE_W-1:0] SAMP_ZERO = {SAMPLE_W{1'b0}};

   // The most negative sample has no positive counterpart, so its negation clamps to full scale.
   function automatic logic signed [SAMPLE_W-1:0] neg_sat(input logic signed [SAMPLE_W-1:0] x);
      if (x == SAMP_MIN) begin
         return SAMP_MAX;
      end else begin
         return -x;
      end
   endfunction

   state_t                     state_q, state_d;
   logic                       data_q;
   logic                       bit_edge_q;
   logic [1:0]                 cur_mode_q, cur_mode_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       edge_s;

   logic                       s1_valid_q;
   logic signed [SAMPLE_W-1:0] s1_sin_q;
   logic signed [SAMPLE_W-1:0] s1_fsk_q;
   logic                       s1_bit_q;
   logic [1:0]                 s1_mode_q;
   logic                       s1_run_q;

   logic signed [SAMPLE_W-1:0] mod_out_q, mod_out_d;
   logic                       mod_valid_q;

   // Edge detection plus next-state for FSM, applied mode and saturating symbol count
   always_comb begin
      edge_s     = (bus.data_bit != data_q);
      state_d    = state_q;
      cur_mode_d = cur_mode_q;
      count_d    = count_q;
      case (state_q)
         WAIT_EDGE: begin
            if (edge_s) begin
               state_d = RUN;
            end else begin
               state_d = WAIT_EDGE;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = WAIT_EDGE;
      endcase
      if (edge_s) begin
         cur_mode_d = bus.mode_req;
      end else begin
         cur_mode_d = cur_mode_q;
      end
      if (edge_s && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Control FSM with registered edge pulse, mode and count
   always_ff @(posedge fast_clk) begin
      if (!rst_n) begin
         state_q    <= WAIT_EDGE;
         data_q     <= 1'b0;
         bit_edge_q <= 1'b0;
         cur_mode_q <= 2'b00;
         count_q    <= {CNT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         data_q     <= bus.data_bit;
         bit_edge_q <= edge_s;
         cur_mode_q <= cur_mode_d;
         count_q    <= count_d;
      end
   end

   // Stage-2 modulation from the snapshot captured in stage 1
   always_comb begin
      mod_out_d = SAMP_ZERO;
      if (!s1_run_q) begin
         mod_out_d = SAMP_ZERO;
      end else begin
         case (s1_mode_q)
            2'b00:   mod_out_d = s1_bit_q ? s1_sin_q : SAMP_ZERO;
            2'b01:   mod_out_d = s1_bit_q ? s1_fsk_q : s1_sin_q;
            2'b10:   mod_out_d = s1_bit_q ? s1_sin_q : neg_sat(s1_sin_q);
            2'b11:   mod_out_d = s1_sin_q;
            default: mod_out_d = SAMP_ZERO;
         endcase
      end
   end

   // Stage 1 snapshots the pre-edge mode/state; stage 2 registers the output
   always_ff @(posedge fast_clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sin_q    <= SAMP_ZERO;
         s1_fsk_q    <= SAMP_ZERO;
         s1_bit_q    <= 1'b0;
         s1_mode_q   <= 2'b00;
         s1_run_q    <= 1'b0;
         mod_valid_q <= 1'b0;
         mod_out_q   <= SAMP_ZERO;
      end else begin
         s1_valid_q <= bus.sample_en;
         if (bus.sample_en) begin
            s1_sin_q  <= bus.sin_in;
            s1_fsk_q  <= bus.fsk_in;
            s1_bit_q  <= bus.data_bit;
            s1_mode_q <= cur_mode_q;
            s1_run_q  <= (state_q == RUN);
         end else begin
            s1_sin_q  <= s1_sin_q;
            s1_fsk_q  <= s1_fsk_q;
            s1_bit_q  <= s1_bit_q;
            s1_mode_q <= s1_mode_q;
            s1_run_q  <= s1_run_q;
         end
         mod_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            mod_out_q <= mod_out_d;
         end else begin
            mod_out_q <= mod_out_q;
         end
      end
   end

   assign bus.mod_out      = mod_out_q;
   assign bus.mod_valid    = mod_valid_q;
   assign bus.cur_mode     = cur_mode_q;
   assign bus.bit_edge     = bit_edge_q;
   assign bus.symbol_count = count_q;
endmodule

// File: doc/lfsr_modulator.md
# lfsr_modulator

Fast-domain modulation stage fed by the slow-to-fast synchronizer: consumes the synchronized LFSR data bit together with DDS carrier samples and produces the modulated output sample (ASK, FSK, BPSK or plain carrier). Mode changes take effect only at data-bit transitions (symbol boundaries), so a symbol is never switched mid-way. Also reports symbol-boundary pulses and a symbol count for the status display.

## Interface
- SAMPLE_W, 12: width of all signed sample buses (two's complement)
- CNT_W, 16: width of symbol_count
- fast_clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising fast_clk
- data_bit  in  1  synchronized LFSR bit, already in fast_clk domain
- sample_en  in  1  one-cycle DDS sample strobe; may be high every cycle
- sin_in  in  SAMPLE_W  signed carrier sample (frequency f0)
- fsk_in  in  SAMPLE_W  signed second-frequency sample (f1), used for FSK
- mode_req  in  2  requested mode: 00 ASK, 01 FSK, 10 BPSK, 11 carrier passthrough
- mod_out  out  SAMPLE_W  signed modulated sample
- mod_valid  out  1  one-cycle pulse, mod_out is new
- cur_mode  out  2  mode currently applied
- bit_edge  out  1  one-cycle pulse per data_bit transition
- symbol_count  out  CNT_W  number of bit_edge pulses since reset, saturating

## Operation
- Edge detect: data_q register (reset 0) samples data_bit every cycle; edge = data_bit != data_q; bit_edge is registered edge. data_bit = 1 at reset release counts as an edge.
- FSM, two states:
  - WAIT_EDGE (reset state): mod_out forced 0; mod_valid still pulses per sample_en so downstream stays fed; first edge -> RUN.
  - RUN: modulation active; only reset leaves RUN.
- On every edge (either state): cur_mode <= mode_req; symbol_count += 1, holding at 2^CNT_W-1 (no wrap). mode_req between edges is ignored.
- Pipeline stage 1 (on sample_en): capture sin_in, fsk_in, data_bit, and the cur_mode value present before that clock edge (an edge in the same cycle does not affect that sample's mode), plus FSM state.
- Stage 2 (registered output):
  - ASK: bit ? sin : 0
  - FSK: bit ? fsk : sin
  - BPSK: bit ? sin : -sin; -(-2^(SAMPLE_W-1)) saturates to 2^(SAMPLE_W-1)-1
  - 11: sin regardless of bit
  - captured state WAIT_EDGE: 0
- mod_out holds its value between mod_valid pulses.

## Timing
- Reset values: mod_out 0, mod_valid 0, cur_mode 00, bit_edge 0, symbol_count 0, data_q 0, FSM WAIT_EDGE, stage-1 valid 0.
- Reset asserted mid-operation clears in-flight samples; no mod_valid is produced for samples accepted before or during reset.
- Latency: sample_en high at edge k -> mod_valid high and mod_out updated at edge k+2. Throughput one sample per cycle.
- data_bit change first sampled at edge k -> bit_edge high after edge k+1 for exactly one cycle; cur_mode and symbol_count update at edge k+1; FSM enters RUN at edge k+1.
- data_bit toggling every cycle: every change produces a bit_edge, count increments each time.
- sample_en with no edge for arbitrarily long: output continues in current mode.

## Test plan
- Reset with data_bit = 0, sample_en pulsing, sin_in = 100 -> mod_valid pulses 2 cycles after each sample_en, mod_out = 0, symbol_count = 0, cur_mode = 00.
- mode_req = 10, toggle data_bit 0->1->0, sin_in = 300 -> cur_mode = 10 after first edge; mod_out = 300 while bit = 1, -300 while bit = 0; symbol_count = 2.
- BPSK, bit 0, sin_in = -2048 -> mod_out = 2047 (saturation).
- mode_req changed 00->01 mid-symbol, no edge -> cur_mode stays 00 until next data_bit change; then FSK: bit 1 gives fsk_in = 55, bit 0 gives sin_in = 77.
- Force 65540 data_bit toggles -> symbol_count stops at 65535, bit_edge still pulses.
- rst_n low one cycle after sample_en in RUN -> no mod_valid for that sample; all outputs at reset values, FSM back in WAIT_EDGE.
